// File: rtl/ps2_key_decoder_if.sv
// Pin and pulse bundle between the board PS/2 pins, the key decoder and the
// game controller's press inputs.
interface ps2_key_decoder_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic       w_press;
    logic       a_press;
    logic       s_press;
    logic       d_press;
    logic       space_press;
    logic       r_press;
    logic       frame_err;
    logic [7:0] scancode;
    logic       scancode_valid;

    // Keyboard / pin side: drives the PS/2 pins, observes the decoded pulses.
    modport master (
        output ps2_clk, ps2_data,
        input  w_press, a_press, s_press, d_press, space_press, r_press,
        input  frame_err, scancode, scancode_valid
    );

    // Decoder side.
    modport slave (
        input  ps2_clk, ps2_data,
        output w_press, a_press, s_press, d_press, space_press, r_press,
        output frame_err, scancode, scancode_valid
    );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: pin synchronizer, ps2_clk glitch filter, 11-bit
// frame receiver with idle timeout, E0/F0 prefix FSM and a per-key held
// register so a typematic key yields one press pulse.
module ps2_key_decoder #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             rst_n,
    ps2_key_decoder_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EXT_BRK} state_t;

    logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic          r_filt;
    logic [4:0]    r_fcnt;
    logic          w_fall;
    logic [3:0]    r_bitcnt;
    logic [9:0]    r_shift;
    logic [TW-1:0] r_tocnt;
    logic [7:0]    r_scancode;
    logic          r_valid, r_err;
    state_t        r_state, w_state_nxt;
    logic [9:0]    r_held, w_held_nxt;
    logic [5:0]    r_press, w_press_nxt;
    logic [3:0]    w_idx;
    logic [2:0]    w_bit;
    logic          w_make, w_brk, w_ext;

    // Held-key index: 0..5 = W A S D Space R, 6..9 = Up Left Down Right, F = unmapped.
    function automatic logic [3:0] key_index(input logic ext, input logic [7:0] code);
        key_index = 4'hF;
        if (!ext) begin
            case (code)
                8'h1D: key_index = 4'd0;
                8'h1C: key_index = 4'd1;
                8'h1B: key_index = 4'd2;
                8'h23: key_index = 4'd3;
                8'h29: key_index = 4'd4;
                8'h2D: key_index = 4'd5;
                default: key_index = 4'hF;
            endcase
        end else begin
            case (code)
                8'h75: key_index = 4'd6;
                8'h6B: key_index = 4'd7;
                8'h72: key_index = 4'd8;
                8'h74: key_index = 4'd9;
                default: key_index = 4'hF;
            endcase
        end
    endfunction

    // Two-flop synchronizers for both pins, idle-high reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= bus.ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= bus.ps2_data;
            r_dat_s2 <= r_dat_s1;
        end
    end

    // Falling edge fires in the cycle the filter accepts a new low level.
    assign w_fall = r_filt && !r_clk_s2 && (r_fcnt == 5'(FILTER_LEN - 1));

    // Glitch filter: accept a new ps2_clk level after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_filt <= 1'b1;
            r_fcnt <= '0;
        end else if (r_clk_s2 == r_filt) begin
            r_fcnt <= '0;
        end else if (r_fcnt == 5'(FILTER_LEN - 1)) begin
            r_filt <= r_clk_s2;
            r_fcnt <= '0;
        end else begin
            r_fcnt <= r_fcnt + 5'd1;
        end
    end

    // Frame receiver and idle timeout; a sampling event always wins over the timeout.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bitcnt   <= '0;
            r_shift    <= '0;
            r_tocnt    <= '0;
            r_scancode <= '0;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            if (w_fall) begin
                r_tocnt <= '0;
                if (r_bitcnt == 4'd10) begin
                    // r_shift holds {parity, d7..d0, start}; the stop bit is on the pin now.
                    if (!r_shift[0] && r_dat_s2 && (^r_shift[9:1])) begin
                        r_scancode <= r_shift[8:1];
                        r_valid    <= 1'b1;
                    end else begin
                        r_err <= 1'b1;
                    end
                    r_bitcnt <= '0;
                end else begin
                    r_shift  <= {r_dat_s2, r_shift[9:1]};
                    r_bitcnt <= r_bitcnt + 4'd1;
                end
            end else if (r_bitcnt != 4'd0) begin
                if (r_tocnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    r_bitcnt <= '0;
                    r_tocnt  <= '0;
                    r_err    <= 1'b1;
                end else begin
                    r_tocnt <= r_tocnt + 1'b1;
                end
            end else begin
                r_tocnt <= '0;
            end
        end
    end

    // Prefix FSM, held-key bookkeeping and press pulse registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_held  <= '0;
            r_press <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_held  <= w_held_nxt;
            r_press <= w_press_nxt;
        end
    end

    // Next state plus make/break decode of each valid byte.
    always_comb begin
        w_state_nxt = r_state;
        w_held_nxt  = r_held;
        w_press_nxt = '0;
        w_make      = 1'b0;
        w_brk       = 1'b0;
        w_ext       = 1'b0;
        if (r_err) begin
            w_state_nxt = ST_IDLE;
        end else if (r_valid) begin
            case (r_state)
                ST_IDLE: begin
                    if (r_scancode == 8'hE0)      w_state_nxt = ST_EXT;
                    else if (r_scancode == 8'hF0) w_state_nxt = ST_BRK;
                    else                          w_make = 1'b1;
                end
                ST_EXT: begin
                    if (r_scancode == 8'hF0) begin
                        w_state_nxt = ST_EXT_BRK;
                    end else begin
                        w_make      = 1'b1;
                        w_ext       = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    w_brk       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
                default: begin
                    w_brk       = 1'b1;
                    w_ext       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
        w_idx = key_index(w_ext, r_scancode);
        w_bit = (w_idx < 4'd6) ? w_idx[2:0] : 3'(w_idx - 4'd6);
        if (w_idx < 4'd10) begin
            if (w_brk) begin
                w_held_nxt[w_idx] = 1'b0;
            end else if (w_make && !r_held[w_idx]) begin
                w_held_nxt[w_idx]  = 1'b1;
                w_press_nxt[w_bit] = 1'b1;
            end
        end
    end

    assign bus.w_press        = r_press[0];
    assign bus.a_press        = r_press[1];
    assign bus.s_press        = r_press[2];
    assign bus.d_press        = r_press[3];
    assign bus.space_press    = r_press[4];
    assign bus.r_press        = r_press[5];
    assign bus.frame_err      = r_err;
    assign bus.scancode       = r_scancode;
    assign bus.scancode_valid = r_valid;
endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: each driven frame pushes its expected
// scancode/error/press events; a negedge monitor pops and compares them.
module tb_ps2_key_decoder;
    localparam int FL = 4;
    localparam int TO = 400;
    localparam int H  = 25;     // PS/2 half bit period in clk cycles

    localparam int EV_VALID = 'h100;
    localparam int EV_ERR   = 'h200;
    localparam int EV_PRESS = 'h300;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ps2_key_decoder_if bus();

    ps2_key_decoder #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;
    int q[$];
    int cyc            = 0;
    int last_valid_cyc = -100;
    int last_stop_cyc  = -100;
    int m_state        = 0;
    logic [9:0] m_held = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic take_event(input int ev);
        if (q.size() == 0) check("unexpected_event", ev, -1);
        else               check("event_order", ev, q.pop_front());
    endtask

    function automatic int norm_idx(input logic [7:0] b);
        case (b)
            8'h1D: return 0;
            8'h1C: return 1;
            8'h1B: return 2;
            8'h23: return 3;
            8'h29: return 4;
            8'h2D: return 5;
            default: return -1;
        endcase
    endfunction

    function automatic int ext_idx(input logic [7:0] b);
        case (b)
            8'h75: return 6;
            8'h6B: return 7;
            8'h72: return 8;
            8'h74: return 9;
            default: return -1;
        endcase
    endfunction

    task automatic model_byte(input logic [7:0] b);
        int idx;
        bit mk;
        idx = -1;
        mk  = 1'b0;
        case (m_state)
            0: if (b == 8'hE0) m_state = 1;
               else if (b == 8'hF0) m_state = 2;
               else begin idx = norm_idx(b); mk = 1'b1; end
            1: if (b == 8'hF0) m_state = 3;
               else begin idx = ext_idx(b); mk = 1'b1; m_state = 0; end
            2: begin idx = norm_idx(b); m_state = 0; end
            default: begin idx = ext_idx(b); m_state = 0; end
        endcase
        if (idx >= 0) begin
            if (!mk) m_held[idx] = 1'b0;
            else if (!m_held[idx]) begin
                m_held[idx] = 1'b1;
                q.push_back(EV_PRESS | ((idx < 6) ? idx : idx - 6));
            end
        end
    endtask

    task automatic ps2_bit(input logic b, input bit last);
        bus.ps2_data = b;
        repeat (H) @(posedge clk);
        #1 bus.ps2_clk = 1'b0;
        if (last) last_stop_cyc = cyc;
        repeat (H) @(posedge clk);
        #1 bus.ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit good);
        logic [10:0] bits;
        if (good) begin
            q.push_back(EV_VALID | int'(b));
            model_byte(b);
        end else begin
            q.push_back(EV_ERR);
            m_state = 0;
        end
        bits = {1'b1, good ? ~^b : ^b, b, 1'b0};
        for (int i = 0; i < 11; i++) ps2_bit(bits[i], i == 10);
        bus.ps2_data = 1'b1;
        repeat (4 * H) @(posedge clk);
    endtask

    task automatic send_partial(input int n);
        for (int i = 0; i < n; i++) ps2_bit((i == 0) ? 1'b0 : 1'b1, 1'b0);
        bus.ps2_data = 1'b1;
    endtask

    function automatic int all_outputs();
        return int'({bus.w_press, bus.a_press, bus.s_press, bus.d_press, bus.space_press,
                     bus.r_press, bus.frame_err, bus.scancode_valid, bus.scancode});
    endfunction

    // Event monitor, sampled mid-cycle.
    always @(negedge clk) begin
        logic [5:0] pr;
        pr = {bus.r_press, bus.space_press, bus.d_press, bus.s_press, bus.a_press, bus.w_press};
        if (rst_n) begin
            if (bus.frame_err || bus.scancode_valid)
                check("err_valid_excl", int'(bus.frame_err & bus.scancode_valid), 0);
            if (bus.frame_err) take_event(EV_ERR);
            if (bus.scancode_valid) begin
                take_event(EV_VALID | int'(bus.scancode));
                last_valid_cyc = cyc;
            end
            if (pr != 6'd0) begin
                check("press_onehot", $countones(pr), 1);
                check("press_after_valid", cyc - last_valid_cyc, 1);
                check("pin_latency_ok", int'((cyc - last_stop_cyc) <= 2 + FL + 2), 1);
                for (int i = 0; i < 6; i++) if (pr[i]) take_event(EV_PRESS | i);
            end
        end
    end

    initial begin
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk) check("reset_outputs", all_outputs(), 0);
        @(posedge clk) #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);

        // W make / break, then typematic repeats
        send_frame(8'h1D, 1'b1);
        send_frame(8'hF0, 1'b1); send_frame(8'h1D, 1'b1);
        for (int i = 0; i < 5; i++) send_frame(8'h1D, 1'b1);
        send_frame(8'hF0, 1'b1); send_frame(8'h1D, 1'b1);
        send_frame(8'h1D, 1'b1);
        send_frame(8'hF0, 1'b1); send_frame(8'h1D, 1'b1);

        // Extended keys; E0 29 unmapped, then plain 29 proves FSM is idle
        send_frame(8'hE0, 1'b1); send_frame(8'h75, 1'b1);
        send_frame(8'hE0, 1'b1); send_frame(8'hF0, 1'b1); send_frame(8'h75, 1'b1);
        send_frame(8'hE0, 1'b1); send_frame(8'h29, 1'b1);
        send_frame(8'h29, 1'b1);
        send_frame(8'hF0, 1'b1); send_frame(8'h29, 1'b1);
        send_frame(8'hE0, 1'b1); send_frame(8'h74, 1'b1);
        send_frame(8'hE0, 1'b1); send_frame(8'h72, 1'b1);

        // Bad parity, and an error dropping a pending E0 prefix
        send_frame(8'h29, 1'b0);
        send_frame(8'h29, 1'b1);
        send_frame(8'hE0, 1'b1); send_frame(8'h29, 1'b0); send_frame(8'h75, 1'b1);

        // Timeout after 5 bits, then a full frame
        q.push_back(EV_ERR);
        m_state = 0;
        send_partial(5);
        repeat (TO + 100) @(posedge clk);
        send_frame(8'h2D, 1'b1);

        // 2-cycle ps2_clk glitch must not register a bit
        @(posedge clk) #1;
        bus.ps2_data = 1'b0;
        bus.ps2_clk  = 1'b0;
        repeat (2) @(posedge clk);
        #1 bus.ps2_clk = 1'b1;
        bus.ps2_data = 1'b1;
        repeat (TO + 100) @(posedge clk);
        send_frame(8'h1C, 1'b1);
        send_frame(8'hE0, 1'b1); send_frame(8'h6B, 1'b1);

        // Up held, then W still fires
        send_frame(8'hE0, 1'b1); send_frame(8'h75, 1'b1);
        send_frame(8'h1D, 1'b1);

        // Reset mid-frame while W is held
        send_partial(3);
        @(posedge clk) #1 rst_n = 1'b0;
        m_state = 0;
        m_held  = '0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk) check("post_reset_outputs", all_outputs(), 0);
        repeat (TO + 100) @(posedge clk);
        send_frame(8'h1D, 1'b1);

        repeat (100) @(posedge clk);
        check("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
